// File: rtl/spi_slave_param.sv
// SPI slave front-end with parametrised payload width and bit order.
// Frame: dummy bit, selector bit S, then W = DATA_W+2 bits {cmd[1:0], payload}.
module spi_slave_param #(
    parameter int unsigned DATA_W    = 8,
    parameter bit          LSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic [DATA_W+1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              frame_err,
    output logic              addr_pending
);

    localparam int unsigned W     = DATA_W + 2;
    localparam int unsigned CNT_W = $clog2(W + 1);

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA,
        TX_WAIT,
        TX_SHIFT,
        HOLD
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [DATA_W-1:0]  r_tx_sr;

    state_t             w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [DATA_W-1:0]  w_tx_sr_nxt;
    logic [W-1:0]       w_rx_data_nxt;
    logic               w_rx_valid_nxt;
    logic               w_frame_err_nxt;
    logic               w_miso_nxt;
    logic               w_addr_pend_nxt;
    logic [CNT_W-1:0]   w_bit_idx;

    // State and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_tx_sr      <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            frame_err    <= 1'b0;
            MISO         <= 1'b0;
            addr_pending <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_tx_sr      <= w_tx_sr_nxt;
            rx_data      <= w_rx_data_nxt;
            rx_valid     <= w_rx_valid_nxt;
            frame_err    <= w_frame_err_nxt;
            MISO         <= w_miso_nxt;
            addr_pending <= w_addr_pend_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_tx_sr_nxt     = r_tx_sr;
        w_rx_data_nxt   = rx_data;
        w_rx_valid_nxt  = 1'b0;
        w_frame_err_nxt = 1'b0;
        w_miso_nxt      = 1'b0;
        w_addr_pend_nxt = addr_pending;
        w_bit_idx       = LSB_FIRST ? (CNT_W'(W) - r_cnt) : (r_cnt - CNT_W'(1));

        case (r_state)
            IDLE: begin
                if (!SS_n) begin
                    w_state_nxt = CHK_CMD;
                end
            end

            CHK_CMD: begin
                if (SS_n) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = CNT_W'(W);
                    if (!MOSI) begin
                        w_state_nxt = WRITE;
                    end else if (addr_pending) begin
                        w_state_nxt = READ_DATA;
                    end else begin
                        w_state_nxt = READ_ADD;
                    end
                end
            end

            WRITE, READ_ADD, READ_DATA: begin
                // The last bit completes the frame even if SS_n rises with it
                if (r_cnt == CNT_W'(1)) begin
                    for (int unsigned i = 0; i < W; i++) begin
                        if (i == 32'(w_bit_idx)) begin
                            w_rx_data_nxt[i] = MOSI;
                        end
                    end
                    w_rx_valid_nxt = 1'b1;
                    w_cnt_nxt      = '0;
                    if (r_state == READ_ADD) begin
                        w_addr_pend_nxt = 1'b1;
                    end
                    if (SS_n) begin
                        w_state_nxt = IDLE;
                    end else if (r_state == READ_DATA) begin
                        w_state_nxt = TX_WAIT;
                    end else begin
                        w_state_nxt = HOLD;
                    end
                end else if (SS_n) begin
                    w_state_nxt     = IDLE;
                    w_frame_err_nxt = 1'b1;
                end else begin
                    for (int unsigned i = 0; i < W; i++) begin
                        if (i == 32'(w_bit_idx)) begin
                            w_rx_data_nxt[i] = MOSI;
                        end
                    end
                    if (r_cnt != '0) begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
            end

            TX_WAIT: begin
                if (SS_n) begin
                    w_state_nxt     = IDLE;
                    w_frame_err_nxt = 1'b1;
                end else if (tx_valid) begin
                    w_cnt_nxt   = CNT_W'(DATA_W - 1);
                    w_state_nxt = TX_SHIFT;
                    if (LSB_FIRST) begin
                        w_miso_nxt  = tx_data[0];
                        w_tx_sr_nxt = tx_data >> 1;
                    end else begin
                        w_miso_nxt  = tx_data[DATA_W-1];
                        w_tx_sr_nxt = tx_data << 1;
                    end
                end
            end

            TX_SHIFT: begin
                if (SS_n) begin
                    w_state_nxt     = IDLE;
                    w_frame_err_nxt = 1'b1;
                end else if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                    if (LSB_FIRST) begin
                        w_miso_nxt  = r_tx_sr[0];
                        w_tx_sr_nxt = r_tx_sr >> 1;
                    end else begin
                        w_miso_nxt  = r_tx_sr[DATA_W-1];
                        w_tx_sr_nxt = r_tx_sr << 1;
                    end
                end else begin
                    w_addr_pend_nxt = 1'b0;
                    w_state_nxt     = HOLD;
                end
            end

            HOLD: begin
                if (SS_n) begin
                    w_state_nxt = IDLE;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule
